sync_updown_mod_counter: RTL
============================

// Module: sync_updown_mod_counter
//
// PURPOSE
//   Parametrised synchronous up/down counter with a programmable modulus.
//   Next generation of the fixed 4-bit T-FF up counter. Adds width and modulus
//   parameters, direction control, count enable, sync clear and parallel load.
//   Provides terminal-count and overflow flags so stages can be cascaded
//   (BCD digits, timers, clock dividers) in the counters library.
//
// PARAMETERS
//   WIDTH      4              counter width in bits (>=1)
//   MAX_COUNT  (2**WIDTH)-1   highest count value; modulus = MAX_COUNT+1;
//                             must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1
//   RESET_VAL  0              value of q after reset/clr; must be <= MAX_COUNT
//
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous reset, active-high
//   en        in   1      count enable (1 = step this cycle)
//   up_dn     in   1      direction: 1 = up, 0 = down
//   clr       in   1      synchronous clear to RESET_VAL
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value for load
//   q         out  WIDTH  current count (registered)
//   tc        out  1      terminal count, combinational: en & (up_dn ? q==MAX_COUNT : q==0)
//   ovf       out  1      registered 1-cycle pulse, high the cycle after a wrap (or a blocked step with SATURATE)
//
// BEHAVIOUR
//   - reset=1 (async, any time): q=RESET_VAL, ovf=0 immediately. This overrides all inputs.
//   - Per rising edge, priority: clr > load > en > hold.
//       clr=1  : q<=RESET_VAL, ovf<=0
//       load=1 : q<=min(load_val, MAX_COUNT), ovf<=0 (out-of-range load clamps)
//       en=1, up_dn=1 : q<=(q==MAX_COUNT) ? 0 : q+1; ovf<=(q==MAX_COUNT)
//       en=1, up_dn=0 : q<=(q==0) ? MAX_COUNT : q-1; ovf<=(q==0)
//       else   : q holds, ovf<=0
//   - Latency: a step appears on q one cycle after the enabling edge. tc has no latency.
//     ovf lags tc by exactly one cycle.
//   - Arithmetic: WIDTH-bit unsigned; q never leaves [0, MAX_COUNT].
//   - Direction change takes effect on the same edge; there is no hold cycle.
//   - Cascade: stage N+1 en = stage N tc; all stages share clk.
//   - Reset released mid-count: counting resumes from RESET_VAL on the first
//     edge with en=1.
//   - If clr and load are asserted together, clr wins. If load and en are
//     asserted together, load wins and no step occurs.
//   - Elaboration: $error if MAX_COUNT or RESET_VAL is out of range.
//
// CONFIGURATION
//   SYNC_UPDOWN_MOD_COUNTER_SATURATE_EN
//     defined  : at a bound, a step holds q (MAX_COUNT up, 0 down) instead of
//                wrapping. ovf pulses for each blocked step. tc is unchanged.
//     undefined: modulo wrap as above (default).
//
// TESTING  (WIDTH=4, MAX_COUNT=9, RESET_VAL=0 unless noted)
//   1. Reset: assert reset mid-count at q=6, asynchronously between edges ->
//      q=0 and ovf=0 before the next edge. Hold en=1 across the reset and
//      check counting restarts at 0.
//   2. Up wrap: en=1, up_dn=1 for 12 clocks -> 1..9,0,1,2. tc is high while
//      q=9. ovf is high for exactly 1 cycle, when q=0.
//   3. Down wrap: from q=1 with up_dn=0 -> 0,9,8. tc is high at q=0. ovf
//      pulses when q=9.
//   4. Priority: clr=1, load=1, load_val=5 -> q=0. Then load=1, load_val=13,
//      en=1 -> q=9 (clamped, no step). en=0 -> q holds for 3 cycles with ovf=0.
//   5. Cascade: two stages form BCD 00..99. After 100 enabled clocks, both
//      digits are 0 and the upper ovf has pulsed once.
//   6. SATURATE_EN defined: up from 8 for 3 clocks -> 9,9,9. ovf pulses on the
//      2 blocked steps. Down from 0 -> q stays 0 and ovf pulses.

Source files
------------

// File: rtl/sync_updown_mod_counter_if.sv
// Control/status bundle for sync_updown_mod_counter.
// master: the block that steers the counter (enable, direction, clear, load).
// slave : the counter itself, returning count, terminal count and overflow.
interface sync_updown_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up_dn, clr, load, load_val,
      input  q, tc, ovf
   );

   modport slave (
      input  en, up_dn, clr, load, load_val,
      output q, tc, ovf
   );
endinterface

// File: rtl/sync_updown_mod_counter.sv
// Parametrised synchronous up/down counter with programmable modulus
// (MAX_COUNT+1), count enable, synchronous clear and clamped parallel load.
// tc flags the step that will wrap so stages can be cascaded (next en = tc);
// ovf is a registered one-cycle pulse following that step.
//
// Build option: define SYNC_UPDOWN_MOD_COUNTER_SATURATE_EN to make a step at
// a bound hold q instead of wrapping; ovf then pulses on every blocked step.
module sync_updown_mod_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = (2 ** WIDTH) - 1,
   parameter int RESET_VAL = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   sync_updown_mod_counter_if.slave  bus
);

   // Reject parameter sets whose count range does not fit the counter.
   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("sync_updown_mod_counter: WIDTH must be >= 1");
      end
      if (MAX_COUNT < 1 || longint'(MAX_COUNT) > ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_bad_max
         $error("sync_updown_mod_counter: MAX_COUNT out of range");
      end
      if (RESET_VAL < 0 || RESET_VAL > MAX_COUNT) begin : g_bad_rst
         $error("sync_updown_mod_counter: RESET_VAL out of range");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO_Q = '0;
   localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next;
   logic             ovf_r;
   logic             ovf_next;
   logic             at_bound;

   // A step in the current direction would cross the range limit.
   assign at_bound = bus.up_dn ? (q_r == MAX_Q) : (q_r == ZERO_Q);

   assign bus.q   = q_r;
   assign bus.ovf = ovf_r;
   assign bus.tc  = bus.en & at_bound;

   // Next count and overflow, priority clr > load > en > hold.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      q_next   = q_r;
      ovf_next = 1'b0;
      if (bus.clr) begin
         q_next = RST_Q;
      end else if (bus.load) begin
         q_next = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
      end else if (bus.en) begin
         ovf_next = at_bound;
         if (at_bound) begin
`ifdef SYNC_UPDOWN_MOD_COUNTER_SATURATE_EN
            q_next = q_r;
`else
            q_next = bus.up_dn ? ZERO_Q : MAX_Q;
`endif
         end else begin
            q_next = bus.up_dn ? (q_r + ONE_Q) : (q_r - ONE_Q);
         end
      end
   end

   // Count and overflow registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         q_r   <= RST_Q;
         ovf_r <= 1'b0;
      end else begin
         q_r   <= q_next;
         ovf_r <= ovf_next;
      end
   end

endmodule
